// File: rtl/ifns_decoder_iter_if.sv
// Handshake bundle for the iterative IFNS decoder: codeword in, decoded value out.
// Both sides use valid/ready: a transfer happens on a rising clock edge where valid and ready are both high.
interface ifns_decoder_iter_if #(
  parameter int CODE_W = 26,
  parameter int DATA_W = 18
);
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W:1]   codein;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dataout;
  logic              ovf;

  modport slave (
    input  in_valid, codein, out_ready,
    output in_ready, out_valid, dataout, ovf
  );

  modport master (
    output in_valid, codein, out_ready,
    input  in_ready, out_valid, dataout, ovf
  );
endinterface

// File: rtl/ifns_decoder_iter.sv
// Multi-cycle Fibonacci-numeral-system decoder: folds BITS_PER_CYCLE codeword bits per cycle
// into a weighted-sum accumulator and hands the result out over valid/ready.
module ifns_decoder_iter #(
  parameter int CODE_W         = 26,
  parameter int DATA_W         = 18,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  ifns_decoder_iter_if.slave   bus,
  output logic [1:0]           dbg_state
);

  localparam int NSTEP  = (CODE_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int SR_W   = NSTEP * BITS_PER_CYCLE;
  localparam int ACC_W  = DATA_W + 2;
  localparam int STEP_W = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [SR_W-1:0]     sr_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    w_cur_q;
  logic [ACC_W-1:0]    w_nxt_q;
  logic [STEP_W-1:0]   step_q;
  logic [DATA_W-1:0]   dataout_q;
  logic                ovf_q;

  logic                accept;
  logic                step_now;
  logic                finish;
  logic [ACC_W-1:0]    acc_step;
  logic [ACC_W-1:0]    w_cur_step;
  logic [ACC_W-1:0]    w_nxt_step;
  logic [ACC_W-1:0]    w_tmp;

  // Next state and per-cycle strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    step_now = 1'b0;
    finish   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_ready_q && bus.in_valid) begin
          accept  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (step_q == STEP_W'(NSTEP)) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end else begin
          step_now = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One chunk of the fold. The weight pair walks the Fibonacci sequence bit by bit, so no
  // weight table is needed; padding bits past CODE_W are zero and contribute nothing.
  always_comb begin
    acc_step   = acc_q;
    w_cur_step = w_cur_q;
    w_nxt_step = w_nxt_q;
    w_tmp      = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (sr_q[j]) acc_step = acc_step + w_cur_step;
      w_tmp      = w_cur_step + w_nxt_step;
      w_cur_step = w_nxt_step;
      w_nxt_step = w_tmp;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sr_q        <= '0;
      acc_q       <= '0;
      w_cur_q     <= '0;
      w_nxt_q     <= '0;
      step_q      <= '0;
      dataout_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      if (accept) begin
        sr_q    <= SR_W'(bus.codein);
        acc_q   <= '0;
        w_cur_q <= ACC_W'(1);
        w_nxt_q <= ACC_W'(2);
        step_q  <= '0;
      end
      if (step_now) begin
        sr_q    <= sr_q >> BITS_PER_CYCLE;
        acc_q   <= acc_step;
        w_cur_q <= w_cur_step;
        w_nxt_q <= w_nxt_step;
        step_q  <= step_q + 1'b1;
      end
      // Result registers only change on entry to DONE, so they hold through the idle gap.
      if (finish) begin
        dataout_q <= acc_q[DATA_W-1:0];
        ovf_q     <= |acc_q[ACC_W-1:DATA_W];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dataout   = dataout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ifns_decoder_iter.sv
// Directed bench for ifns_decoder_iter: reset, single-bit sweep, overflow, stall, reset abort,
// and a random comparison of three BITS_PER_CYCLE variants against a Fibonacci reference.
module tb_ifns_decoder_iter;

  localparam int CODE_W = 26;
  localparam int DATA_W = 18;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic [1:0] dbg_m, dbg_1, dbg_4, dbg_26;

  int n_checks = 0;
  int n_fail   = 0;

  ifns_decoder_iter_if #(.CODE_W(CODE_W), .DATA_W(DATA_W)) bus_m ();
  ifns_decoder_iter_if #(.CODE_W(CODE_W), .DATA_W(DATA_W)) bus_1 ();
  ifns_decoder_iter_if #(.CODE_W(CODE_W), .DATA_W(DATA_W)) bus_4 ();
  ifns_decoder_iter_if #(.CODE_W(CODE_W), .DATA_W(DATA_W)) bus_26 ();

  ifns_decoder_iter #(.CODE_W(CODE_W), .DATA_W(DATA_W), .BITS_PER_CYCLE(2)) dut_m (
    .clock(clock), .rst(rst), .bus(bus_m), .dbg_state(dbg_m));
  ifns_decoder_iter #(.CODE_W(CODE_W), .DATA_W(DATA_W), .BITS_PER_CYCLE(1)) dut_1 (
    .clock(clock), .rst(rst), .bus(bus_1), .dbg_state(dbg_1));
  ifns_decoder_iter #(.CODE_W(CODE_W), .DATA_W(DATA_W), .BITS_PER_CYCLE(4)) dut_4 (
    .clock(clock), .rst(rst), .bus(bus_4), .dbg_state(dbg_4));
  ifns_decoder_iter #(.CODE_W(CODE_W), .DATA_W(DATA_W), .BITS_PER_CYCLE(26)) dut_26 (
    .clock(clock), .rst(rst), .bus(bus_26), .dbg_state(dbg_26));

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Reference: sum of codein[k]*W(k), W(1)=1, W(2)=2, W(k)=W(k-1)+W(k-2).
  function automatic longint ref_sum(input logic [CODE_W-1:0] code);
    longint a, b, t, s;
    a = 1; b = 2; s = 0;
    for (int k = 0; k < CODE_W; k++) begin
      if (code[k]) s += a;
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  function automatic longint fib_w(input int k);
    longint a, b, t;
    a = 1; b = 2;
    for (int i = 1; i < k; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  // Offer one codeword on the main instance and follow it to the hand-off (out_ready assumed high).
  task automatic run_code(input string tag, input logic [CODE_W-1:0] code,
                          input logic [31:0] exp_data, input logic exp_ovf, input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!bus_m.in_ready && guard < 10) begin tick(); guard++; end
    check({tag, "_in_ready"}, 32'(bus_m.in_ready), 32'd1);
    bus_m.in_valid = 1'b1;
    bus_m.codein   = code;
    tick();
    bus_m.in_valid = 1'b0;
    lat = 0;
    while (!bus_m.out_valid && lat < 100) begin tick(); lat++; end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(bus_m.dataout), exp_data);
    check({tag, "_ovf"}, 32'(bus_m.ovf), 32'(exp_ovf));
    tick();
    check({tag, "_valid_drop"}, 32'(bus_m.out_valid), 32'd0);
  endtask

  initial begin
    logic [CODE_W-1:0] code;
    longint            s;
    logic [31:0]       exp_d;
    logic              exp_o;
    int                lat1, lat4, lat26;
    bit                seen1, seen4, seen26;
    bit                any_valid;

    bus_m.in_valid  = 1'b0; bus_m.codein  = '0; bus_m.out_ready  = 1'b1;
    bus_1.in_valid  = 1'b0; bus_1.codein  = '0; bus_1.out_ready  = 1'b1;
    bus_4.in_valid  = 1'b0; bus_4.codein  = '0; bus_4.out_ready  = 1'b1;
    bus_26.in_valid = 1'b0; bus_26.codein = '0; bus_26.out_ready = 1'b1;

    // ---- reset state ----
    tick(); tick();
    check("rst_in_ready",  32'(bus_m.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus_m.out_valid), 32'd0);
    check("rst_dataout",   32'(bus_m.dataout),   32'd0);
    check("rst_ovf",       32'(bus_m.ovf),       32'd0);
    check("rst_state",     32'(dbg_m),           32'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(bus_m.in_ready), 32'd1);

    // ---- first codeword ----
    run_code("code_1", 26'h1, 32'd1, 1'b0, 14);

    // ---- single-bit sweep ----
    for (int k = 1; k <= CODE_W; k++) begin
      code = '0;
      code[k-1] = 1'b1;
      run_code($sformatf("bit_%0d", k), code, 32'(fib_w(k)), 1'b0, 14);
    end
    run_code("bit3_const",  26'h4,       32'd3,      1'b0, 14);
    run_code("bit26_const", 26'h2000000, 32'd196418, 1'b0, 14);
    run_code("zero",        26'h0,       32'd0,      1'b0, 14);
    run_code("all_ones",    26'h3FFFFFF, 32'd252083, 1'b1, 14);

    // ---- stall in DONE: 1 + 3 = 4, new offers ignored ----
    bus_m.out_ready = 1'b0;
    bus_m.in_valid  = 1'b1;
    bus_m.codein    = 26'h5;
    tick();
    bus_m.codein    = 26'h2;
    lat1 = 0;
    while (!bus_m.out_valid && lat1 < 100) begin tick(); lat1++; end
    check("stall_latency", 32'(lat1), 32'd14);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid",    32'(bus_m.out_valid), 32'd1);
      check("stall_data",     32'(bus_m.dataout),   32'd4);
      check("stall_ovf",      32'(bus_m.ovf),       32'd0);
      check("stall_in_ready", 32'(bus_m.in_ready),  32'd0);
    end
    bus_m.in_valid  = 1'b0;
    bus_m.out_ready = 1'b1;
    tick();
    check("stall_release_valid", 32'(bus_m.out_valid), 32'd0);
    check("stall_hold_data",     32'(bus_m.dataout),   32'd4);
    tick();
    check("stall_idle_ready",    32'(bus_m.in_ready),  32'd1);

    // ---- reset on BUSY cycle 5 aborts the result ----
    bus_m.in_valid = 1'b1;
    bus_m.codein   = 26'h3FFFFFF;
    tick();
    bus_m.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_busy_state", 32'(dbg_m), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus_m.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus_m.in_ready),  32'd0);
    check("abort_dataout",   32'(bus_m.dataout),   32'd0);
    check("abort_state",     32'(dbg_m),           32'd0);
    tick();
    rst = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_m.out_valid) any_valid = 1'b1;
    end
    check("abort_no_result", 32'(any_valid), 32'd0);
    run_code("after_abort", 26'h4, 32'd3, 1'b0, 14);

    // ---- BITS_PER_CYCLE 1 / 4 / 26 against the reference ----
    for (int n = 0; n < 1000; n++) begin
      code  = CODE_W'($urandom_range(0, (1 << CODE_W) - 1));
      s     = ref_sum(code);
      exp_d = 32'(s % (64'd1 << DATA_W));
      exp_o = (s >= (64'd1 << DATA_W));
      bus_1.codein  = code; bus_1.in_valid  = 1'b1;
      bus_4.codein  = code; bus_4.in_valid  = 1'b1;
      bus_26.codein = code; bus_26.in_valid = 1'b1;
      tick();
      bus_1.in_valid = 1'b0; bus_4.in_valid = 1'b0; bus_26.in_valid = 1'b0;
      seen1 = 1'b0; seen4 = 1'b0; seen26 = 1'b0;
      lat1 = 0; lat4 = 0; lat26 = 0;
      for (int c = 1; c <= 40 && !(seen1 && seen4 && seen26); c++) begin
        tick();
        if (bus_1.out_valid && !seen1) begin
          seen1 = 1'b1; lat1 = c;
          check("bpc1_data", 32'(bus_1.dataout), exp_d);
          check("bpc1_ovf",  32'(bus_1.ovf),     32'(exp_o));
        end
        if (bus_4.out_valid && !seen4) begin
          seen4 = 1'b1; lat4 = c;
          check("bpc4_data", 32'(bus_4.dataout), exp_d);
          check("bpc4_ovf",  32'(bus_4.ovf),     32'(exp_o));
        end
        if (bus_26.out_valid && !seen26) begin
          seen26 = 1'b1; lat26 = c;
          check("bpc26_data", 32'(bus_26.dataout), exp_d);
          check("bpc26_ovf",  32'(bus_26.ovf),     32'(exp_o));
        end
      end
      check("bpc1_latency",  32'(lat1),  32'd27);
      check("bpc4_latency",  32'(lat4),  32'd8);
      check("bpc26_latency", 32'(lat26), 32'd2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
